// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM state encoding,
// score entry field positions and the tempo reload helper.
package note_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4,
        ST_PAUSED = 3'd5
    } state_t;

    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 8;
    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 0;

    localparam logic [7:0] END_DUR   = 8'd0;
    localparam logic [7:0] REST_NOTE = 8'd0;

    // A tempo of 0 behaves like 1 clock per unit; returns the unit counter load value.
    function automatic logic [23:0] unit_reload(input logic [23:0] unit_clks);
        if (unit_clks == 24'd0) begin
            return 24'd0;
        end else begin
            return unit_clks - 24'd1;
        end
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Processor-facing bus of the note sequencer: score write port, tempo and
// transport commands in; synthesizer drive and status out.
interface note_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [23:0]       unit_clks;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic              pause;
    logic [7:0]        note;
    logic              playing;
    logic              busy;
    logic [ADDR_W-1:0] cur_addr;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, unit_clks, loop_en, start, stop, pause,
        input  note, playing, busy, cur_addr, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, unit_clks, loop_en, start, stop, pause,
        output note, playing, busy, cur_addr, done
    );
endinterface

// File: rtl/note_sequencer_score_ram.sv
// Score buffer: DEPTH x 16 simple dual-port RAM with a registered read port.
// A read of the address being written in the same cycle returns the old entry.
module score_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);
    logic [15:0] mem_r [DEPTH];
    logic [15:0] rd_data_r;

    // Write port and registered read; non-blocking update gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data_r <= mem_r[rd_addr];
    end

    assign rd_data = rd_data_r;
endmodule

// File: rtl/note_sequencer.sv
// Hardware score player: fetches (note, duration) entries from the score RAM
// and drives the synthesizer note code and enable with unit-accurate timing,
// an articulation gap between notes, looping and pause/resume.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 6,
    parameter int unsigned GAP_CLKS = 250000
) (
    input  logic             Clk,
    input  logic             Rst,
    note_sequencer_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       GAP_LOAD  = (GAP_CLKS == 32'd0) ? 32'd0 : 32'(GAP_CLKS - 32'd1);

    state_t            state_r;
    state_t            ret_state_r;
    logic [7:0]        note_r;
    logic              playing_r;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [23:0]       unit_cnt_r;
    logic [7:0]        dur_cnt_r;
    logic [31:0]       gap_cnt_r;

    logic [15:0]       rd_data_s;
    logic [7:0]        rd_note_s;
    logic [7:0]        rd_dur_s;
    logic [23:0]       unit_reload_s;
    logic              play_last_s;
    logic [23:0]       unit_nxt_s;
    logic [7:0]        dur_nxt_s;
    logic              pausable_s;
    state_t            end_state_s;
    logic [ADDR_W-1:0] end_addr_s;
    logic              end_done_s;
    state_t            adv_state_s;
    logic [ADDR_W-1:0] adv_addr_s;
    logic              adv_done_s;

    score_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_score_ram (
        .clk     (Clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (cur_addr_r),
        .rd_data (rd_data_s)
    );

    assign rd_note_s     = rd_data_s[NOTE_MSB:NOTE_LSB];
    assign rd_dur_s      = rd_data_s[DUR_MSB:DUR_LSB];
    assign unit_reload_s = unit_reload(bus.unit_clks);
    assign play_last_s   = (unit_cnt_r == 24'd0) && (dur_cnt_r == 8'd1);
    assign pausable_s    = (state_r == ST_FETCH) || (state_r == ST_LOAD) ||
                           (state_r == ST_PLAY)  || (state_r == ST_GAP);

    // One PLAY-cycle step of the unit/duration counters (used when not on the last cycle).
    always_comb begin
        unit_nxt_s = unit_cnt_r;
        dur_nxt_s  = dur_cnt_r;
        if (unit_cnt_r == 24'd0) begin
            unit_nxt_s = unit_reload_s;
            dur_nxt_s  = dur_cnt_r - 8'd1;
        end else begin
            unit_nxt_s = unit_cnt_r - 24'd1;
            dur_nxt_s  = dur_cnt_r;
        end
    end

    // End-of-score decision (loop back or finish) and the post-gap advance that reuses it.
    always_comb begin
        end_state_s = ST_IDLE;
        end_addr_s  = cur_addr_r;
        end_done_s  = 1'b1;
        if (bus.loop_en && (cur_addr_r != '0)) begin
            end_state_s = ST_FETCH;
            end_addr_s  = '0;
            end_done_s  = 1'b0;
        end else begin
            end_state_s = ST_IDLE;
            end_addr_s  = cur_addr_r;
            end_done_s  = 1'b1;
        end

        adv_state_s = ST_FETCH;
        adv_addr_s  = cur_addr_r;
        adv_done_s  = 1'b0;
        if (cur_addr_r == LAST_ADDR) begin
            adv_state_s = end_state_s;
            adv_addr_s  = end_addr_s;
            adv_done_s  = end_done_s;
        end else begin
            adv_state_s = ST_FETCH;
            adv_addr_s  = cur_addr_r + ADDR_W'(1);
            adv_done_s  = 1'b0;
        end
    end

    // Playback controller: command arbitration (stop > pause > start), state sequencing,
    // counters and registered synthesizer/status outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= ST_IDLE;
            ret_state_r <= ST_IDLE;
            note_r      <= 8'd0;
            playing_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cur_addr_r  <= '0;
            unit_cnt_r  <= 24'd0;
            dur_cnt_r   <= 8'd0;
            gap_cnt_r   <= 32'd0;
        end else begin
            done_r <= 1'b0;
            if (bus.stop) begin
                state_r   <= ST_IDLE;
                busy_r    <= 1'b0;
                note_r    <= 8'd0;
                playing_r <= 1'b0;
            end else if (bus.pause && pausable_s) begin
                state_r     <= ST_PAUSED;
                ret_state_r <= state_r;
                busy_r      <= 1'b1;
                playing_r   <= 1'b0;
                // The cycle the pause lands in was audible, so charge it to the note
                // unless it is the note's final cycle.
                if ((state_r == ST_PLAY) && !play_last_s) begin
                    unit_cnt_r <= unit_nxt_s;
                    dur_cnt_r  <= dur_nxt_s;
                end
            end else if ((bus.pause || bus.start) && (state_r == ST_PAUSED)) begin
                state_r <= ret_state_r;
                busy_r  <= 1'b1;
                if (ret_state_r == ST_PLAY) begin
                    playing_r <= (note_r != REST_NOTE);
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state_r    <= ST_FETCH;
                            busy_r     <= 1'b1;
                            cur_addr_r <= '0;
                        end
                    end
                    ST_FETCH: begin
                        state_r <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (rd_dur_s == END_DUR) begin
                            state_r    <= end_state_s;
                            cur_addr_r <= end_addr_s;
                            done_r     <= end_done_s;
                            busy_r     <= (end_state_s != ST_IDLE);
                            if (end_state_s == ST_IDLE) begin
                                note_r    <= 8'd0;
                                playing_r <= 1'b0;
                            end
                        end else begin
                            note_r     <= rd_note_s;
                            playing_r  <= (rd_note_s != REST_NOTE);
                            unit_cnt_r <= unit_reload_s;
                            dur_cnt_r  <= rd_dur_s;
                            state_r    <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (play_last_s) begin
                            playing_r <= 1'b0;
                            if (GAP_CLKS == 32'd0) begin
                                state_r    <= adv_state_s;
                                cur_addr_r <= adv_addr_s;
                                done_r     <= adv_done_s;
                                busy_r     <= (adv_state_s != ST_IDLE);
                                if (adv_state_s == ST_IDLE) begin
                                    note_r <= 8'd0;
                                end
                            end else begin
                                state_r   <= ST_GAP;
                                gap_cnt_r <= GAP_LOAD;
                            end
                        end else begin
                            unit_cnt_r <= unit_nxt_s;
                            dur_cnt_r  <= dur_nxt_s;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_r == 32'd0) begin
                            state_r    <= adv_state_s;
                            cur_addr_r <= adv_addr_s;
                            done_r     <= adv_done_s;
                            busy_r     <= (adv_state_s != ST_IDLE);
                            if (adv_state_s == ST_IDLE) begin
                                note_r <= 8'd0;
                            end
                        end else begin
                            gap_cnt_r <= gap_cnt_r - 32'd1;
                        end
                    end
                    ST_PAUSED: begin
                        state_r <= ST_PAUSED;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        note_r    <= 8'd0;
                        playing_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.note     = note_r;
    assign bus.playing  = playing_r;
    assign bus.busy     = busy_r;
    assign bus.cur_addr = cur_addr_r;
    assign bus.done     = done_r;
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Hardware score player that drives the frequency synthesizer's note code and playing inputs without per-note Nios II intervention.
- Nios II loads a score of (note, duration) entries into an internal buffer, sets the tempo, and issues start/stop/pause.
- The block steps through the score with unit-accurate timing, inserting an articulation gap between notes.
- Sits between the processor's PIO outputs and FreqSynth and replaces direct onote/playing writes during playback.

Parameters:
DEPTH, 64, score entries (power of two)
ADDR_W, 6, log2(DEPTH)
GAP_CLKS, 250000, silent clocks between consecutive notes (5 ms at 50 MHz); 0 = legato

Ports:
Clk  in  1  system clock, 50 MHz
Rst  in  1  synchronous reset, active-high
wr_en  in  1  score write strobe
wr_addr  in  ADDR_W  score write address
wr_data  in  16  entry: [15:8] note code, [7:0] duration in units
unit_clks  in  24  clocks per duration unit (tempo)
loop_en  in  1  restart at entry 0 on end of score
start  in  1  pulse: begin at entry 0 from IDLE, or resume from PAUSED
stop  in  1  pulse: abort to IDLE
pause  in  1  pulse: freeze playback (toggles while PAUSED)
note  out  8  note code to FreqSynth
playing  out  1  synthesizer enable
busy  out  1  high in any state except IDLE
cur_addr  out  ADDR_W  entry currently fetched or played
done  out  1  one-cycle pulse on natural end of score

Behaviour:
- Clock and reset: one clock, Clk; reset Rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - note=0, playing=0, busy=0, cur_addr=0, done=0.
  - All counters are 0.
  - Score contents are undefined (not cleared).
- Entry semantics:
  - A duration of 0 is the end marker.
  - Note code 0 is a rest: playing=0 for the entry's duration.
- States: IDLE, FETCH, LOAD, PLAY, GAP, PAUSED.
- IDLE: on start, set cur_addr=0 and go to FETCH.
- FETCH: present cur_addr to the synchronous RAM. Exactly one cycle; always go to LOAD.
- LOAD: read data is valid in this cycle.
  - If dur=0 (end marker) and loop_en=1 and cur_addr!=0: set cur_addr=0 and go to FETCH.
  - Otherwise, if dur=0: go to IDLE, pulse done, drive note=0 and playing=0.
  - Otherwise: note<=code; playing<=(code!=0); unit_cnt<=max(unit_clks,1)-1; dur_cnt<=dur; go to PLAY.
- PLAY:
  - unit_cnt decrements every cycle.
  - When unit_cnt=0: if dur_cnt=1, go to GAP; else dur_cnt decrements and unit_cnt reloads from unit_clks, sampled at each reload.
  - Total PLAY time is dur*max(unit_clks,1) cycles.
- GAP:
  - playing=0 and note is held.
  - Lasts GAP_CLKS cycles; if GAP_CLKS=0, GAP lasts 0 cycles and the advance happens directly from PLAY.
  - Advance rule: if cur_addr=DEPTH-1, treat it as an end marker (apply the LOAD end rules without a fetch). Otherwise cur_addr+1, then FETCH.
- Start-to-sound latency: start accepted in IDLE makes playing=1 three cycles later (FETCH, LOAD, registered output).
- PAUSED:
  - Entered from FETCH, LOAD, PLAY or GAP on pause.
  - Saves the return state and freezes all counters; playing=0 while paused.
  - pause or start in PAUSED returns to the saved state.
  - On return to PLAY, playing is restored to (note!=0).
- Command priority per cycle: stop > pause > start.
  - stop in any state: go to IDLE next cycle with note=0 and playing=0; no done pulse.
  - start outside IDLE/PAUSED is ignored.
- Score writes:
  - Allowed at any time, including during playback.
  - A write and a read of the same address in the same cycle returns the old data.
- unit_clks changes take effect at the next unit reload, not mid-unit.
- Degenerate scores:
  - End marker at entry 0 with loop_en=1: go to IDLE with done, which avoids a zero-time loop.
  - loop_en is sampled at end-of-score time.

Decomposition:
- Package note_seq_pkg:
  - State encoding constants.
  - Entry field positions: NOTE_MSB/LSB=15/8, DUR_MSB/LSB=7/0.
  - END_DUR=0 and REST_NOTE=0.
- Sub-module score_ram:
  - DEPTH x 16, one write port, registered read port.
  - Old-data-on-collision behaviour.
  - Infers block RAM.
- Controller FSM, counters and output registers live in note_sequencer.

Test Plan:
- Three-entry score with unit_clks=4 and GAP_CLKS=2:
  - Stimulus: entries {0x21,3}, {0x00,1}, {0x00,0}, then start.
  - Required: playing=1 with note=0x21 for 12 cycles; 2 gap cycles; playing=0 rest for 4 cycles; 2 gap cycles; one done pulse; busy falls.
- Loop with loop_en=1:
  - Stimulus: same score as above.
  - Required: after the end marker, cur_addr returns to 0 and note 0x21 replays; no done pulse. Then stop gives IDLE next cycle, playing=0, done never asserted.
- Pause and resume:
  - Stimulus: pause at cycle 5 of a 12-cycle note, wait 100 cycles, then start.
  - Required: playing=0 for those 100 cycles, then the note resumes and sounds for exactly 7 more cycles.
- Full buffer wrap:
  - Stimulus: all 64 entries with dur=1, loop_en=0.
  - Required: after entry 63, a done pulse with no fetch of an entry 64. With loop_en=1, cur_addr wraps 63 to 0.
- Simultaneous commands and degenerate tempo:
  - Stimulus: stop, pause and start asserted together during PLAY.
  - Required: stop wins and the block goes to IDLE.
  - Stimulus: unit_clks=0 with dur=2.
  - Required: 2 cycles of PLAY.
- Reset and write collision:
  - Stimulus: Rst asserted mid-PLAY.
  - Required: all outputs 0 on the next cycle.
  - Stimulus: write to cur_addr during FETCH.
  - Required: LOAD uses the old entry.
